// File: rtl/sdram_pattern_writer.sv
// Fills an SDRAM region with a deterministic pattern over Avalon-MM,
// then holds a done flag for the read-back stage.
//
// Ports:
//   iCLK          system clock, rising edge
//   iRST          asynchronous active-high reset
//   iSTART        start pulse (level acts as repeated pulses)
//   iWAIT_REQUEST Avalon stall; current write not accepted while high
//   oWR_EN        Avalon write request
//   oWR_ADDR      {frame[5:0], row[9:0], col[8:0]}
//   oWR_DATA      pattern word derived from the current address
//   oBUSY         high while writing
//   oDONE         high once the whole region has been written
//   oWORD_CNT     words accepted since the last start
module sdram_pattern_writer #(
  parameter int          N_COLS    = 512,
  parameter int          N_ROWS    = 1024,
  parameter int          N_FRAMES  = 64,
  parameter logic [19:0] INIT_WAIT = 20'd1000000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iWAIT_REQUEST,
  output logic        oWR_EN,
  output logic [24:0] oWR_ADDR,
  output logic [15:0] oWR_DATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [25:0] oWORD_CNT
);

  localparam logic [8:0] COL_LAST   = 9'(N_COLS - 1);
  localparam logic [9:0] ROW_LAST   = 10'(N_ROWS - 1);
  localparam logic [5:0] FRAME_LAST = 6'(N_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [19:0] r_init;
  logic [8:0]  r_col;
  logic [9:0]  r_row;
  logic [5:0]  r_frame;
  logic [25:0] r_word_cnt;

  logic        w_ready;
  logic        w_accept;
  logic        w_col_last;
  logic        w_row_last;
  logic        w_frame_last;
  logic        w_last;
  logic        w_start;

  assign w_ready      = (r_init == INIT_WAIT);
  assign w_accept     = (r_state == S_WRITE) && !iWAIT_REQUEST;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_frame_last = (r_frame == FRAME_LAST);
  assign w_last       = w_col_last && w_row_last && w_frame_last;

  // Entering WRITE from IDLE or DONE begins a fresh pass.
  assign w_start = (w_next == S_WRITE) && (r_state != S_WRITE);

  // Power-up settling counter; saturates at INIT_WAIT.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_init <= 20'd0;
    end else if (!w_ready) begin
      r_init <= r_init + 20'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iSTART && w_ready) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (iSTART) begin
          w_next = S_WRITE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oWR_EN = 1'b0;
    oBUSY  = 1'b0;
    oDONE  = 1'b0;
    case (r_state)
      S_WRITE: begin
        oWR_EN = 1'b1;
        oBUSY  = 1'b1;
      end
      S_DONE: begin
        oDONE = 1'b1;
      end
      default: begin
        oWR_EN = 1'b0;
      end
    endcase
  end

  // Address counters advance only on an accepted transfer, so
  // address and data stay frozen across stalls.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_col   <= 9'd0;
      r_row   <= 10'd0;
      r_frame <= 6'd0;
    end else if (w_start) begin
      r_col   <= 9'd0;
      r_row   <= 10'd0;
      r_frame <= 6'd0;
    end else if (w_accept) begin
      if (w_last) begin
        r_col   <= 9'd0;
        r_row   <= 10'd0;
        r_frame <= 6'd0;
      end else if (w_col_last) begin
        r_col <= 9'd0;
        if (w_row_last) begin
          r_row   <= 10'd0;
          r_frame <= r_frame + 6'd1;
        end else begin
          r_row <= r_row + 10'd1;
        end
      end else begin
        r_col <= r_col + 9'd1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_word_cnt <= 26'd0;
    end else if (w_start) begin
      r_word_cnt <= 26'd0;
    end else if (w_accept) begin
      r_word_cnt <= r_word_cnt + 26'd1;
    end
  end

  assign oWR_ADDR      = {r_frame, r_row, r_col};
  assign oWR_DATA[15:8] = r_row[7:0] + {2'b00, r_frame};
  assign oWR_DATA[7:0]  = r_col[7:0] ^ {2'b00, r_frame};
  assign oWORD_CNT     = r_word_cnt;

endmodule
